// File: rtl/semamem_pkg.sv
// Shared types and field positions for the counting semaphore memory.
package semamem_pkg;

    localparam int OP_BITS   = 3;
    localparam int BYTE_BITS = 2;

    // Operation field sits in the top OP_BITS of the address; the word index follows below it.
    typedef enum logic [OP_BITS-1:0] {
        OP_LOCK   = 3'd0,
        OP_UNLOCK = 3'd1,
        OP_GIVE   = 3'd2,
        OP_TAKE   = 3'd3,
        OP_CLEAR  = 3'd4,
        OP_WRITE  = 3'd5
    } sema_op_t;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        RD,
        MOD,
        ACK
    } sema_state_t;

endpackage

// File: rtl/counting_semamem_if.sv
// Slave bus bundle for the semaphore memory; clock and reset stay outside.
interface counting_semamem_if #(
    parameter int AW        = 15,
    parameter int DATA_BITS = 32
) ();
    logic                 cs_i;
    logic                 cyc_i;
    logic                 stb_i;
    logic                 ack_o;
    logic                 we_i;
    logic [AW-1:0]        adr_i;
    logic [DATA_BITS-1:0] dat_i;
    logic [DATA_BITS-1:0] dat_o;
    logic                 busy_o;

    modport master (
        output cs_i, cyc_i, stb_i, we_i, adr_i, dat_i,
        input  ack_o, dat_o, busy_o
    );

    modport slave (
        input  cs_i, cyc_i, stb_i, we_i, adr_i, dat_i,
        output ack_o, dat_o, busy_o
    );
endinterface

// File: rtl/semamem_alu.sv
// Combinational update rule: stored word, operand and op code give the new word.
module semamem_alu
    import semamem_pkg::*;
#(
    parameter int                   DATA_BITS = 32,
    parameter int                   KEY_BITS  = 24,
    parameter logic [DATA_BITS-1:0] COUNT_MAX = '1
) (
    input  logic [DATA_BITS-1:0] old,
    input  logic [DATA_BITS-1:0] d,
    input  logic [OP_BITS-1:0]   op,
    output logic [DATA_BITS-1:0] result
);

    logic [DATA_BITS:0] sum;

    always_comb begin
        // Extra carry bit lets give saturate instead of wrapping.
        sum    = {1'b0, old} + {1'b0, d};
        result = d;
        case (op)
            OP_LOCK:   result = (old == '0) ? d : old;
            OP_UNLOCK: result = (old[KEY_BITS-1:0] == d[KEY_BITS-1:0]) ? '0 : old;
            OP_GIVE:   result = (sum > {1'b0, COUNT_MAX}) ? COUNT_MAX : sum[DATA_BITS-1:0];
            OP_TAKE:   result = (old >= d) ? old - d : old;
            OP_CLEAR:  result = '0;
            default:   result = d;
        endcase
    end

endmodule

// File: rtl/counting_semamem.sv
// Bank of atomic semaphore words; one FSM serialises every read-modify-write.
module counting_semamem
    import semamem_pkg::*;
#(
    parameter int                   DEPTH     = 1024,
    parameter int                   DATA_BITS = 32,
    parameter int                   KEY_BITS  = 24,
    parameter logic [DATA_BITS-1:0] COUNT_MAX = '1,
    parameter int                   AW        = $clog2(DEPTH) + 5
) (
    input logic              clk_i,
    input logic              rst_i,
    counting_semamem_if.slave bus
);

    localparam int IW = $clog2(DEPTH);

    sema_state_t          state, state_nxt;
    logic [IW-1:0]        sweep;
    logic                 ack_q;
    logic [DATA_BITS-1:0] dat_q;
    logic [IW-1:0]        idx_q;
    logic [OP_BITS-1:0]   op_q;
    logic                 we_q;
    logic [DATA_BITS-1:0] d_q;
    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [DATA_BITS-1:0] rd_data;
    logic [DATA_BITS-1:0] alu_result;
    logic                 ram_we;
    logic [IW-1:0]        ram_wadr;
    logic [DATA_BITS-1:0] ram_wdata;
    logic                 req;
    logic                 unused_bits;

    assign req         = bus.cs_i & bus.cyc_i & bus.stb_i;
    assign unused_bits = ^bus.adr_i[BYTE_BITS-1:0];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= INIT;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            INIT:    if (sweep == IW'(DEPTH - 1)) state_nxt = IDLE;
            IDLE:    if (req) state_nxt = RD;
            RD:      state_nxt = MOD;
            MOD:     state_nxt = ACK;
            ACK:     if (!req) state_nxt = IDLE;
            default: state_nxt = INIT;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sweep <= '0;
            ack_q <= 1'b0;
            dat_q <= '0;
        end else begin
            if (state == INIT) sweep <= sweep + 1'b1;
            if (state == MOD)  dat_q <= rd_data;
            // Ack follows the request in ACK, so a withdrawn request never sees one.
            ack_q <= (state == ACK) ? req : 1'b0;
        end
    end

    // Request fields are captured at sampling so a withdrawn request still completes.
    always_ff @(posedge clk_i) begin
        if (state == IDLE) begin
            idx_q <= bus.adr_i[AW-OP_BITS-1:BYTE_BITS];
            op_q  <= bus.adr_i[AW-1 -: OP_BITS];
            we_q  <= bus.we_i;
            d_q   <= bus.dat_i;
        end
    end

    semamem_alu #(
        .DATA_BITS (DATA_BITS),
        .KEY_BITS  (KEY_BITS),
        .COUNT_MAX (COUNT_MAX)
    ) u_alu (
        .old    (rd_data),
        .d      (d_q),
        .op     (op_q),
        .result (alu_result)
    );

    // Write lands in MOD, before ACK, so a following access reads the new value directly.
    assign ram_we    = (state == INIT) | ((state == MOD) & we_q);
    assign ram_wadr  = (state == INIT) ? sweep : idx_q;
    assign ram_wdata = (state == INIT) ? '0 : alu_result;

    always_ff @(posedge clk_i) begin
        if (ram_we) mem[ram_wadr] <= ram_wdata;
        rd_data <= mem[idx_q];
    end

    assign bus.ack_o  = ack_q;
    assign bus.dat_o  = dat_q;
    assign bus.busy_o = (state == INIT);

endmodule

// File: tb/tb_counting_semamem.sv
// Randomised and directed bench for counting_semamem with a queued scoreboard.
module tb_counting_semamem;

    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH) + 5;

    typedef struct {
        logic [31:0] dat;
        int          issue;
        bit          chk_lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          cyc_cnt = 0;
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] model [DEPTH];
    exp_t        sb [$];

    counting_semamem_if #(.AW(AW), .DATA_BITS(32)) bus ();

    counting_semamem #(
        .DEPTH     (DEPTH),
        .DATA_BITS (32),
        .KEY_BITS  (24),
        .AW        (AW)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_apply(input logic [2:0] op, input logic [31:0] old,
                                              input logic [31:0] d);
        longint s;
        case (op)
            3'd0: return (old == 0) ? d : old;
            3'd1: return ((old & 32'h00FF_FFFF) == (d & 32'h00FF_FFFF)) ? 32'h0 : old;
            3'd2: begin
                s = longint'(old) + longint'(d);
                return (s > 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : s[31:0];
            end
            3'd3: return (old >= d) ? old - d : old;
            3'd4: return 32'h0;
            default: return d;
        endcase
    endfunction

    task automatic drive(input bit we, input logic [2:0] op, input int idx, input logic [31:0] d);
        logic [1:0] junk;
        junk        = 2'($urandom_range(0, 3));
        bus.cs_i    = 1'b1;
        bus.cyc_i   = 1'b1;
        bus.stb_i   = 1'b1;
        bus.we_i    = we;
        bus.adr_i   = {op, 4'(idx), junk};
        bus.dat_i   = d;
    endtask

    task automatic idle_bus();
        bus.cs_i  = 1'b0;
        bus.cyc_i = 1'b0;
        bus.stb_i = 1'b0;
        bus.we_i  = 1'b0;
    endtask

    task automatic wait_ack();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = bus.ack_o;
        end
        check("ack_seen", 32'(got), 32'd1);
        idle_bus();
    endtask

    task automatic do_op(input bit we, input logic [2:0] op, input int idx, input logic [31:0] d);
        exp_t e;
        @(negedge clk);
        e.dat     = model[idx];
        e.issue   = cyc_cnt + 1;
        e.chk_lat = 1'b1;
        if (we) model[idx] = ref_apply(op, model[idx], d);
        sb.push_back(e);
        drive(we, op, idx, d);
        wait_ack();
    endtask

    task automatic rd(input int idx);
        do_op(1'b0, 3'($urandom_range(0, 7)), idx, $urandom);
    endtask

    task automatic wait_sweep(output int n);
        n = 0;
        while (bus.busy_o && n < 4 * DEPTH) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
    endtask

    initial begin : monitor
        exp_t e;
        logic ack_prev;
        ack_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.ack_o && !ack_prev) begin
                if (sb.size() == 0) begin
                    check("unexpected_ack", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("dat_o", bus.dat_o, e.dat);
                    if (e.chk_lat) check("ack_latency", 32'(cyc_cnt - e.issue), 32'd3);
                    check("busy_at_ack", 32'(bus.busy_o), 32'd0);
                end
            end
            ack_prev = bus.ack_o;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin : stim
        exp_t        e;
        int          n;
        int          idx;
        logic [2:0]  op;
        logic [31:0] d;
        for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
        idle_bus();
        bus.adr_i = '0;
        bus.dat_i = '0;
        repeat (3) @(negedge clk);
        check("reset_ack", 32'(bus.ack_o), 32'd0);
        check("reset_dat", bus.dat_o, 32'd0);
        check("reset_busy", 32'(bus.busy_o), 32'd1);

        // Read of word 5 issued while the sweep is still running.
        rst       = 1'b0;
        e.dat     = 32'h0;
        e.issue   = 0;
        e.chk_lat = 1'b0;
        sb.push_back(e);
        drive(1'b0, 3'd0, 5, 32'h0);
        wait_sweep(n);
        check("busy_cycles", 32'(n), 32'(DEPTH));
        wait_ack();

        do_op(1'b1, 3'd0, 3, 32'h00A5_A5A5);
        rd(3);
        do_op(1'b1, 3'd0, 3, 32'h0011_1111);
        rd(3);
        do_op(1'b1, 3'd1, 3, 32'hFF11_1111);
        rd(3);
        do_op(1'b1, 3'd1, 3, 32'hFFA5_A5A5);
        rd(3);

        do_op(1'b1, 3'd2, 7, 32'd2);
        do_op(1'b1, 3'd3, 7, 32'd3);
        rd(7);
        do_op(1'b1, 3'd3, 7, 32'd2);
        rd(7);

        do_op(1'b1, 3'd2, 9, 32'hFFFF_FFF0);
        do_op(1'b1, 3'd2, 9, 32'hFFFF_FFF0);
        rd(9);

        do_op(1'b1, 3'd2, 11, 32'd1);
        do_op(1'b1, 3'd2, 11, 32'd1);
        rd(11);

        do_op(1'b1, 3'd7, 12, 32'hCAFE_F00D);
        rd(12);
        do_op(1'b1, 3'd4, 12, 32'h1234_0000);
        rd(12);

        // Request dropped while in RD: the give still lands but no ack appears.
        @(negedge clk);
        model[2] = ref_apply(3'd2, model[2], 32'd5);
        drive(1'b1, 3'd2, 2, 32'd5);
        @(negedge clk);
        idle_bus();
        repeat (4) @(negedge clk);
        rd(2);

        for (int k = 0; k < 60; k++) begin
            idx = $urandom_range(0, 3);
            op  = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0: d = 32'($urandom_range(0, 6));
                1: d = model[idx] | (32'($urandom_range(0, 255)) << 24);
                2: d = $urandom;
                default: d = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            endcase
            do_op(($urandom_range(0, 3) != 0), op, idx, d);
        end

        // Reset asserted while a raw write to word 4 sits in MOD.
        do_op(1'b1, 3'd5, 4, 32'hDEAD_BEEF);
        @(negedge clk);
        drive(1'b1, 3'd6, 4, 32'h1234_5678);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_mid_ack", 32'(bus.ack_o), 32'd0);
        idle_bus();
        repeat (2) @(negedge clk);
        check("rst_mid_busy", 32'(bus.busy_o), 32'd1);
        check("rst_mid_dat", bus.dat_o, 32'd0);
        for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
        rst = 1'b0;
        wait_sweep(n);
        check("busy_cycles_2", 32'(n), 32'(DEPTH));
        rd(4);
        rd(3);
        rd(9);

        repeat (6) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/counting_semamem.md
Name: counting_semamem

Overview:
- Parametrised successor to the binary semaphore memory: a bank of DEPTH atomic semaphore words on the shared slave bus.
- Supports binary lock/unlock with key compare, counting take/give with saturation, raw write, clear and plain read.
- The read-modify-write is performed internally, so no bus master can observe or interleave a partial update.
- Writes return the pre-operation value so software learns success in one transaction; sits beside other slave cores behind the system address decoder.

Parameters:
- DEPTH, 1024, number of semaphore words; power of two, 16..4096.
- DATA_BITS, 32, semaphore word width.
- KEY_BITS, 24, LSBs compared on unlock; must be <= DATA_BITS.
- COUNT_MAX, 2**DATA_BITS-1, saturation ceiling for give.
- AW, $clog2(DEPTH)+5, adr_i width: 3 op bits, index bits, 2 byte bits.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset, asynchronous, active-high.
- cs_i  in  1  core select.
- cyc_i  in  1  bus cycle.
- stb_i  in  1  strobe.
- ack_o  out  1  transfer acknowledge.
- we_i  in  1  write enable.
- adr_i  in  AW  [AW-1:AW-3] op, [AW-4:2] word index, [1:0] ignored.
- dat_i  in  DATA_BITS  key/count/value.
- dat_o  out  DATA_BITS  word value before the operation.
- busy_o  out  1  high during the post-reset clear sweep.

Behaviour:
- Reset (async, rst_i=1): state INIT, ack_o=0, dat_o=0, busy_o=1, sweep index=0.
- The memory array itself is not reset; it is cleared by the sweep.
- INIT: writes 0 to one word per clock, index 0..DEPTH-1, then moves to IDLE with busy_o=0 (DEPTH clocks).
  - Requests during INIT are not acked; they stall until IDLE.
- Request = cs_i & cyc_i & stb_i, sampled in IDLE.
- State sequence: IDLE -> RD (RAM address registered) -> MOD (old value valid; compute new value; write RAM if we_i; dat_o<=old) -> ACK.
- ACK: ack_o=1, held while the request stays high. When the request drops, ack_o<=0 and the state returns to IDLE.
- ack_o rises 3 clocks after the sampling edge.
- The RAM write completes before ack_o. Back-to-back operations on the same word therefore see the updated value; no forwarding is needed.
- we_i=0: read only; the op field is ignored and the word is unchanged.
- we_i=1, op decode (old = stored word, d = dat_i):
  - 000 try-lock: new = (old==0) ? d : old.
  - 001 unlock: new = (old[KEY_BITS-1:0]==d[KEY_BITS-1:0]) ? 0 : old.
  - 010 give: new = min(old+d, COUNT_MAX), computed in DATA_BITS+1 bits; no wrap.
  - 011 take: new = (old>=d) ? old-d : old. All-or-nothing; never below 0.
  - 100 clear: new = 0.
  - 101-111 raw write: new = d.
- Software success tests: try-lock succeeded iff dat_o==0. Take succeeded iff dat_o>=d.
- Atomicity: a single FSM serialises all requests; there is no concurrency inside the block.
- Reset mid-operation: the FSM is aborted, no ack is issued, the pending write is dropped, and the sweep restarts at index 0.
- Request withdrawn before ACK (stb_i low in RD/MOD): the operation still completes. ACK then sees the request low and returns to IDLE without asserting ack_o.
- dat_o holds its last value outside transfers.

Decomposition:
- Package semamem_pkg:
  - sema_op_t enum (OP_LOCK, OP_UNLOCK, OP_GIVE, OP_TAKE, OP_CLEAR, OP_WRITE).
  - sema_state_t enum (INIT, IDLE, RD, MOD, ACK).
  - Op-field position constants.
- Sub-module semamem_alu (combinational): old, d, op -> new value. Parametrised by DATA_BITS, KEY_BITS, COUNT_MAX.
- RAM is inferred in the top level as a block RAM with a registered read.

Test Plan:
- Reset, then read word 5 after busy_o falls -> dat_o=0. busy_o stays high exactly DEPTH clocks; a request issued during INIT acks only after the sweep.
- Try-lock word 3 with 0x00A5A5A5 -> dat_o=0, then a read returns 0x00A5A5A5. A second try-lock with 0x00111111 -> dat_o=0x00A5A5A5 and the word is unchanged.
- Unlock word 3 with 0xFF111111 -> no change (key mismatch). Unlock with 0xFFA5A5A5 -> dat_o=0x00A5A5A5 and a read returns 0 (only 24 LSBs compared).
- Give word 7 by 2, then take 3 -> take returns dat_o=2 with word still 2. Take 2 -> word 0.
- Give 0xFFFFFFF0 twice to word 9 -> word saturates at 0xFFFFFFFF.
- Assert rst_i in MOD of a raw write of 0x12345678 -> no ack; after the sweep, a read returns 0. Back-to-back gives of 1 to the same word with no idle -> exact count 2. ack_o latency is 3 clocks every time.
